md5_msg_padder: RTL and testbench
=================================

Name: md5_msg_padder

Overview:
Upstream stage of the MD5 hash wrapper. Accepts a message as a byte stream, packs bytes into 512-bit blocks and applies MD5 padding: a 0x80 byte, zero fill, and a 64-bit little-endian bit length. Emits one or more blocks per message over a valid/ready handshake. Each block is ready for the compression core without further formatting.

Parameters:
LEN_BITS, 64, width of internal bit-length counter (16..64); length field bits above LEN_BITS are zero; counter wraps mod 2^LEN_BITS.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
s_data  input  8  message byte
s_valid  input  1  s_data valid
s_last  input  1  qualifies s_data as final byte of message
s_ready  output  1  padder accepts byte this cycle
block_data  output  512  padded block; byte i at bits [8i+7:8i]
block_valid  output  1  block_data valid
block_last  output  1  block is final block of message (contains length)
block_ready  input  1  consumer accepts block this cycle
busy  output  1  message in progress (any state but FILL with byte_cnt=0 and no bytes taken)

Behaviour:
- Reset, asynchronous: s_ready=0 during reset, 1 the first cycle after release. block_valid=0, block_last=0, block_data=0, busy=0, byte_cnt=0, bit_len=0, state FILL.
- Byte accept = s_valid & s_ready. The accepted byte is written to byte position byte_cnt. byte_cnt increments. bit_len increases by 8.
- Block layout: 32-bit words are little-endian, matching MD5 word order.
- States:
  - FILL: s_ready=1.
    - Accept with byte_cnt=63 and !s_last -> EMIT (block_last=0), byte_cnt<=0.
    - Accept with s_last -> PAD (the byte is written first).
  - PAD: one cycle, s_ready=0. p = byte_cnt after the last write (1..64).
    - p=64 -> EMIT with pad_pending=1 and pad_start=0.
    - p<=55 -> write 0x80 at p, zeros at p+1..55, bit_len LE at 56..63. Go to EMIT with block_last=1.
    - 56<=p<=63 -> write 0x80 at p, zeros at p+1..63. Go to EMIT with len_pending=1.
  - EMIT: block_valid=1, s_ready=0. block_data and block_last are held stable until block_ready.
    - On handshake with len_pending: load a block of zeros with bit_len at 56..63, block_last=1. Stay in EMIT, block_valid asserted again next cycle.
    - On handshake with pad_pending: load a block with 0x80 at byte 0, zeros, and bit_len at 56..63, block_last=1. Stay in EMIT.
    - On handshake otherwise: if block_last, clear bit_len and busy. Return to FILL, buffer zeroed, byte_cnt=0.
- Latency: block_valid rises the cycle after the 64th byte, or the cycle after PAD. Minimum gap between blocks is 1 cycle (valid low one cycle between consecutive blocks).
- Zero-length messages are unsupported; s_last always accompanies a real byte.
- s_last with s_valid=0 is ignored.
- Reset mid-operation aborts the message. No partial block is emitted after reset.
- Length overflow: the counter wraps silently.

Test Plan:
- Message "abc" (0x61,0x62,0x63, last on 0x63) -> one block. Word0=0x80636261, bytes 4..55 zero, byte56=0x18, bytes57..63=0, block_last=1.
- 55 bytes of 0x41 -> one block. byte55=0x80, byte56=0xB8, byte57=0x01, block_last=1.
- 56 bytes of 0x41 -> block1 has byte55=0x41, byte56=0x80, rest zero, block_last=0. Block2 is zero except byte56=0xC0, byte57=0x01, block_last=1.
- 64 bytes 0x00..0x3F -> block1 equals raw bytes, block_last=0. Block2 has byte0=0x80, byte56=0x00, byte57=0x02, block_last=1.
- 130-byte message with block_ready held low 10 cycles per block -> block_data/block_last stable while stalled, s_ready=0 throughout EMIT. Three blocks emitted; final length 0x410 (bytes 56..57 = 0x10,0x04).
- Reset asserted after 20 bytes, then "abc" sent -> no stale bytes in output. Output identical to the first scenario; busy=0 during reset.

Source files
------------

// File: rtl/md5_msg_padder.sv
// MD5 message padder: packs a byte stream into 512-bit blocks, appends 0x80,
// zero fill and the 64-bit little-endian bit length, and hands blocks downstream.
module md5_msg_padder #(
  parameter int LEN_BITS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic [511:0] block_data,
  output logic         block_valid,
  output logic         block_last,
  input  logic         block_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t              state;
  logic [6:0]          byte_cnt;
  logic [LEN_BITS-1:0] bit_len;
  logic                len_pending;
  logic                pad_pending;
  logic                in_msg;
  logic [63:0]         len64;
  logic                accept;
  logic                handshake;

  // Length field is always 64 bits wide; bits above LEN_BITS read as zero.
  always_comb begin
    len64 = '0;
    len64[LEN_BITS-1:0] = bit_len;
  end

  assign s_ready   = (state == FILL) && !reset;
  assign accept    = s_valid && s_ready;
  assign handshake = (state == EMIT) && block_valid && block_ready;
  assign busy      = in_msg;

  // Each byte lane owns its own register and decides its next value locally.
  for (genvar gi = 0; gi < 64; gi++) begin : g_byte
    localparam logic [6:0] IDX      = 7'(gi);
    localparam bit         IN_LEN   = (gi >= 56);
    localparam bit         IS_FIRST = (gi == 0);

    logic [7:0] len_byte;
    logic [7:0] nx;
    logic [7:0] data;
    logic       we;

    if (gi >= 56) begin : g_len
      assign len_byte = len64[8*(gi-56) +: 8];
    end else begin : g_msg
      assign len_byte = 8'h00;
    end

    always_comb begin
      we = 1'b0;
      nx = 8'h00;
      case (state)
        FILL: begin
          if (accept && (byte_cnt == IDX)) begin
            we = 1'b1;
            nx = s_data;
          end
        end
        PAD: begin
          // byte_cnt holds the first free position; 64 means no room at all.
          if (byte_cnt == IDX) begin
            we = 1'b1;
            nx = 8'h80;
          end else if (byte_cnt < IDX) begin
            we = 1'b1;
            nx = (IN_LEN && (byte_cnt <= 7'd55)) ? len_byte : 8'h00;
          end
        end
        EMIT: begin
          if (handshake) begin
            we = 1'b1;
            if (IN_LEN && (len_pending || pad_pending)) begin
              nx = len_byte;
            end else if (IS_FIRST && pad_pending) begin
              nx = 8'h80;
            end
          end
        end
        default: begin
          we = 1'b0;
          nx = 8'h00;
        end
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data <= 8'h00;
      end else if (we) begin
        data <= nx;
      end
    end

    assign block_data[8*gi +: 8] = data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      byte_cnt    <= 7'd0;
      bit_len     <= '0;
      block_valid <= 1'b0;
      block_last  <= 1'b0;
      len_pending <= 1'b0;
      pad_pending <= 1'b0;
      in_msg      <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            bit_len <= bit_len + LEN_BITS'(8);
            in_msg  <= 1'b1;
            if (s_last) begin
              state    <= PAD;
              byte_cnt <= byte_cnt + 7'd1;
            end else if (byte_cnt == 7'd63) begin
              state       <= EMIT;
              byte_cnt    <= 7'd0;
              block_valid <= 1'b1;
              block_last  <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + 7'd1;
            end
          end
        end
        PAD: begin
          state       <= EMIT;
          byte_cnt    <= 7'd0;
          block_valid <= 1'b1;
          if (byte_cnt == 7'd64) begin
            pad_pending <= 1'b1;
            block_last  <= 1'b0;
          end else if (byte_cnt <= 7'd55) begin
            block_last <= 1'b1;
          end else begin
            len_pending <= 1'b1;
            block_last  <= 1'b0;
          end
        end
        EMIT: begin
          if (!block_valid) begin
            // One idle cycle separates a block from the trailer block behind it.
            block_valid <= 1'b1;
          end else if (block_ready) begin
            block_valid <= 1'b0;
            if (len_pending || pad_pending) begin
              len_pending <= 1'b0;
              pad_pending <= 1'b0;
              block_last  <= 1'b1;
            end else begin
              state      <= FILL;
              block_last <= 1'b0;
              if (block_last) begin
                bit_len <= '0;
                in_msg  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md5_msg_padder.sv
// Directed bench for md5_msg_padder: table of messages with hand-computed key
// bytes, whole-block comparison against a reference padding model, reset cases.
module tb_md5_msg_padder;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   s_data = 8'h00;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic [511:0] block_data;
  logic         block_valid;
  logic         block_last;
  logic         block_ready = 1'b0;
  logic         busy;

  md5_msg_padder #(.LEN_BITS(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .block_data  (block_data),
    .block_valid (block_valid),
    .block_last  (block_last),
    .block_ready (block_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int              len;
    int              mode;
    int              stall;
    int              nblk;
    logic [3:0][1:0] cblk;
    logic [3:0][5:0] cidx;
    logic [3:0][7:0] cval;
  } vec_t;

  localparam int TMO = 2000;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [511:0] got_data [4];
  logic         got_last [4];
  int           got_n;
  vec_t         vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out after %0d cycles, expected DUT response", name, TMO);
  endtask

  function automatic logic [7:0] mbyte(input int mode, input int i);
    case (mode)
      0:       return 8'(8'h61 + i);
      2:       return 8'(i);
      default: return 8'h41;
    endcase
  endfunction

  // Reference MD5 padding of the whole message, returning block b.
  function automatic logic [511:0] model_block(input int len, input int mode, input int b);
    logic [511:0] r;
    logic [63:0]  bits;
    int           total;
    int           k;
    r     = '0;
    bits  = 64'(len) * 64'd8;
    total = ((len + 8) / 64 + 1) * 64;
    for (int j = 0; j < 64; j++) begin
      k = b * 64 + j;
      if (k < len)              r[8*j +: 8] = mbyte(mode, k);
      else if (k == len)        r[8*j +: 8] = 8'h80;
      else if (k >= total - 8)  r[8*j +: 8] = bits[8*(k-total+8) +: 8];
    end
    return r;
  endfunction

  function automatic vec_t mk(input int len, input int mode, input int stall, input int nblk,
                              input int b0, input int i0, input logic [7:0] v0,
                              input int b1, input int i1, input logic [7:0] v1,
                              input int b2, input int i2, input logic [7:0] v2,
                              input int b3, input int i3, input logic [7:0] v3);
    vec_t r;
    r.len = len; r.mode = mode; r.stall = stall; r.nblk = nblk;
    r.cblk[0] = 2'(b0); r.cidx[0] = 6'(i0); r.cval[0] = v0;
    r.cblk[1] = 2'(b1); r.cidx[1] = 6'(i1); r.cval[1] = v1;
    r.cblk[2] = 2'(b2); r.cidx[2] = 6'(i2); r.cval[2] = v2;
    r.cblk[3] = 2'(b3); r.cidx[3] = 6'(i3); r.cval[3] = v3;
    return r;
  endfunction

  task automatic send_msg(input int len, input int mode, input bit with_last);
    for (int i = 0; i < len; i++) begin
      int n;
      @(negedge clk);
      s_data  = mbyte(mode, i);
      s_valid = 1'b1;
      s_last  = with_last && (i == len - 1);
      n = 0;
      while (!s_ready && n < TMO) begin
        @(negedge clk);
        n++;
      end
      if (n >= TMO) begin
        fail_timeout("send_s_ready");
        break;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic recv(input int nblk, input int stall);
    got_n = 0;
    for (int b = 0; b < nblk; b++) begin
      int           n;
      logic [511:0] snap;
      logic         snap_last;
      bit           stable;
      n = 0;
      @(negedge clk);
      while (!block_valid && n < TMO) begin
        @(negedge clk);
        n++;
      end
      if (n >= TMO) begin
        fail_timeout($sformatf("recv_block%0d", b));
        return;
      end
      snap      = block_data;
      snap_last = block_last;
      stable    = 1'b1;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        if (block_data !== snap || block_last !== snap_last ||
            s_ready !== 1'b0 || block_valid !== 1'b1) stable = 1'b0;
      end
      if (stall > 0) chk($sformatf("stall_hold_blk%0d", b), 64'(stable), 64'd1);
      block_ready = 1'b1;
      got_data[b] = block_data;
      got_last[b] = block_last;
      got_n++;
      @(negedge clk);
      block_ready = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    fork
      send_msg(v.len, v.mode, 1'b1);
      recv(v.nblk, v.stall);
    join
    chk($sformatf("v%0d.nblk", vi), 64'(got_n), 64'(v.nblk));
    for (int b = 0; b < got_n; b++) begin
      chk_blk($sformatf("v%0d.block%0d", vi, b), got_data[b], model_block(v.len, v.mode, b));
      chk($sformatf("v%0d.last%0d", vi, b), 64'(got_last[b]), 64'(b == v.nblk - 1));
    end
    for (int c = 0; c < 4; c++) begin
      if (int'(v.cblk[c]) < got_n)
        chk($sformatf("v%0d.blk%0d_byte%0d", vi, v.cblk[c], v.cidx[c]),
            64'(got_data[v.cblk[c]][8*v.cidx[c] +: 8]), 64'(v.cval[c]));
      else
        fail_timeout($sformatf("v%0d.missing_blk%0d", vi, v.cblk[c]));
    end
    @(negedge clk);
    chk($sformatf("v%0d.idle_valid", vi), 64'(block_valid), 64'd0);
    chk($sformatf("v%0d.idle_busy", vi), 64'(busy), 64'd0);
    $display("msg %0d: len=%0d stall=%0d blocks=%0d", vi, v.len, v.stall, got_n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //            len mode stall nblk | key bytes {blk, idx, value} x4
    vecs[0] = mk(  3, 0, 0,  1,  0, 3,8'h80, 0,56,8'h18, 0, 0,8'h61, 0,57,8'h00);
    vecs[1] = mk( 55, 1, 0,  1,  0,55,8'h80, 0,56,8'hB8, 0,57,8'h01, 0,54,8'h41);
    vecs[2] = mk( 56, 1, 0,  2,  0,55,8'h41, 0,56,8'h80, 1,56,8'hC0, 1,57,8'h01);
    vecs[3] = mk( 63, 1, 0,  2,  0,62,8'h41, 0,63,8'h80, 1,56,8'hF8, 1,57,8'h01);
    vecs[4] = mk( 64, 2, 0,  2,  0,63,8'h3F, 1, 0,8'h80, 1,56,8'h00, 1,57,8'h02);
    vecs[5] = mk(130, 2, 10, 3,  1, 0,8'h40, 2, 2,8'h80, 2,56,8'h10, 2,57,8'h04);

    repeat (3) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_block_valid", 64'(block_valid), 64'd0);
    chk("rst_block_last", 64'(block_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk_blk("rst_block_data", block_data, 512'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", 64'(s_ready), 64'd1);

    for (int vi = 0; vi < 6; vi++) run_vec(vecs[vi], vi);

    // Abort a partially received message with reset, then send "abc" again.
    send_msg(20, 1, 1'b0);
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_no_block", 64'(block_valid), 64'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    chk_blk("mid_rst_block_data", block_data, 512'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[0], 6);
    chk("abc_word0", 64'(got_data[0][31:0]), 64'h80636261);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
